// File: rtl/textlcd_pkg.sv
// Shared definitions for the text-LCD read and write sequencers.
// Holds the HD44780 command codes, the read-request op encoding, the
// reader state enum and the default bus/exec timing constants.
package textlcd_pkg;

  localparam logic [7:0] CMD_SET_DDRAM = 8'h80;

  localparam logic OP_RD_BF   = 1'b0;
  localparam logic OP_RD_DATA = 1'b1;

  localparam int unsigned TEXTLCD_SETUP_CYC = 200;
  localparam int unsigned TEXTLCD_PULSE_CYC = 1600;
  localparam int unsigned TEXTLCD_HOLD_CYC  = 100;
  localparam int unsigned TEXTLCD_EXEC_CYC  = 2000;
  localparam int unsigned TEXTLCD_POLL_MAX  = 64;

  typedef enum logic [2:0] {
    StIdle,
    StSetAddr,
    StExecWait,
    StPoll,
    StRdCyc,
    StDone
  } textlcd_state_e;

endpackage

// File: rtl/textlcd_bus_cycle.sv
// One LCD bus cycle timer: SETUP_CYC clocks of setup, PULSE_CYC clocks of EN
// high, HOLD_CYC clocks of hold. A start pulse (allowed on the done clock for
// back-to-back cycles) restarts the phase counter at 0.
// Ports:
//   clk_i, rst_ni  clock, async active-low reset
//   start_i        begin a cycle on this edge (phase 0 follows)
//   lcd_en_o       registered EN strobe
//   sample_o       high on the last EN-high clock (capture DB here)
//   done_o         high on the last phase of the cycle
module textlcd_bus_cycle #(
  parameter int unsigned SETUP_CYC = 200,
  parameter int unsigned PULSE_CYC = 1600,
  parameter int unsigned HOLD_CYC  = 100
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic start_i,
  output logic lcd_en_o,
  output logic sample_o,
  output logic done_o
);

  localparam int unsigned CycT = SETUP_CYC + PULSE_CYC + HOLD_CYC;
  localparam int unsigned PhW  = $clog2(CycT);

  logic [PhW-1:0] phase_q, phase_d;
  logic           active_q, active_d;
  logic           en_q, en_d;

  always_comb begin
    phase_d  = phase_q;
    active_d = active_q;
    if (start_i) begin
      phase_d  = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      if (phase_q == PhW'(CycT - 1)) begin
        phase_d  = '0;
        active_d = 1'b0;
      end else begin
        phase_d = phase_q + 1'b1;
      end
    end
    // EN is decoded from the next phase so the pin itself comes from a flop.
    en_d = active_d && (phase_d >= PhW'(SETUP_CYC)) &&
           (phase_d <= PhW'(SETUP_CYC + PULSE_CYC - 1));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase_q  <= '0;
      active_q <= 1'b0;
      en_q     <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      active_q <= active_d;
      en_q     <= en_d;
    end
  end

  assign lcd_en_o = en_q;
  assign sample_o = active_q && (phase_q == PhW'(SETUP_CYC + PULSE_CYC - 1));
  assign done_o   = active_q && (phase_q == PhW'(CycT - 1));

endmodule

// File: rtl/textlcd_reader.sv
// HD44780-style character-LCD read controller. Accepts one read request at a
// time: op 0 reads BF/AC (RS=0), op 1 sets the DDRAM address with a write
// cycle, waits, then reads the DDRAM byte (RS=1). Result arrives as a
// one-clock rd_valid_o pulse with rd_data_o held until the next pulse.
// Build option: define TEXTLCD_READER_BUSY_POLL_EN to replace the fixed
// post-address wait with busy-flag polling (bounded by POLL_MAX, err_o on
// timeout with rd_data_o = 0xFF). Without it err_o is tied low.
// Ports:
//   clk_i, rst_ni                   clock, async active-low reset
//   req_i, req_op_i, req_addr_i     request strobe (sampled when ready_o), op, address
//   ready_o                         high only in idle
//   rd_valid_o, rd_data_o, err_o    result pulse, byte, error qualifier
//   lcd_rs_o, lcd_rw_o, lcd_en_o    LCD control pins
//   lcd_data_out_o, lcd_data_oe_o   pad drive data and enable (write cycles only)
//   lcd_data_in_i                   pad input
module textlcd_reader
  import textlcd_pkg::*;
#(
  parameter int unsigned SETUP_CYC = TEXTLCD_SETUP_CYC,
  parameter int unsigned PULSE_CYC = TEXTLCD_PULSE_CYC,
  parameter int unsigned HOLD_CYC  = TEXTLCD_HOLD_CYC,
  parameter int unsigned EXEC_CYC  = TEXTLCD_EXEC_CYC,
  parameter int unsigned POLL_MAX  = TEXTLCD_POLL_MAX
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       req_i,
  input  logic       req_op_i,
  input  logic [6:0] req_addr_i,
  output logic       ready_o,
  output logic       rd_valid_o,
  output logic [7:0] rd_data_o,
  output logic       err_o,
  output logic       lcd_rs_o,
  output logic       lcd_rw_o,
  output logic       lcd_en_o,
  output logic [7:0] lcd_data_out_o,
  output logic       lcd_data_oe_o,
  input  logic [7:0] lcd_data_in_i
);

  // Zero-length timing phases are not supported.
  if (SETUP_CYC == 0 || PULSE_CYC == 0 || HOLD_CYC == 0 || EXEC_CYC == 0 ||
      POLL_MAX == 0) begin : g_bad_timing_param
  end

  textlcd_state_e state_q;
  logic           op_q;
  logic [7:0]     samp_q;
  logic           rs_q, rw_q, oe_q;
  logic [7:0]     dout_q;
  logic           rd_valid_q;
  logic [7:0]     rd_data_q;
  logic           bus_start, bus_sample, bus_done;

`ifdef TEXTLCD_READER_BUSY_POLL_EN
  localparam int unsigned PollW = $clog2(POLL_MAX + 1);
  logic [PollW-1:0] poll_cnt_q;
  logic             err_q, err_pend_q;
  logic             poll_give_up;
  assign poll_give_up = samp_q[7] && (poll_cnt_q == PollW'(POLL_MAX));
`else
  localparam int unsigned ExecW = $clog2(EXEC_CYC + 1);
  logic [ExecW-1:0] exec_cnt_q;
  logic             exec_done;
  assign exec_done = (state_q == StExecWait) && (exec_cnt_q == ExecW'(EXEC_CYC - 1));
`endif

  textlcd_bus_cycle #(
    .SETUP_CYC (SETUP_CYC),
    .PULSE_CYC (PULSE_CYC),
    .HOLD_CYC  (HOLD_CYC)
  ) u_bus (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .start_i  (bus_start),
    .lcd_en_o (lcd_en_o),
    .sample_o (bus_sample),
    .done_o   (bus_done)
  );

  // Bus cycles start on exactly the edges where the FSM enters a bus state.
  always_comb begin
    bus_start = 1'b0;
    unique case (state_q)
      StIdle:     bus_start = req_i;
`ifdef TEXTLCD_READER_BUSY_POLL_EN
      StSetAddr:  bus_start = bus_done;
      StPoll:     bus_start = bus_done && !poll_give_up;
`else
      StSetAddr:  bus_start = 1'b0;
      StExecWait: bus_start = exec_done;
`endif
      default:    bus_start = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      op_q       <= OP_RD_BF;
      samp_q     <= '0;
      rs_q       <= 1'b0;
      rw_q       <= 1'b0;
      oe_q       <= 1'b0;
      dout_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
`ifdef TEXTLCD_READER_BUSY_POLL_EN
      poll_cnt_q <= '0;
      err_q      <= 1'b0;
      err_pend_q <= 1'b0;
`else
      exec_cnt_q <= '0;
`endif
    end else begin
      rd_valid_q <= 1'b0;
`ifdef TEXTLCD_READER_BUSY_POLL_EN
      err_q      <= 1'b0;
`endif
      if (bus_sample) samp_q <= lcd_data_in_i;
      unique case (state_q)
        StIdle: begin
          if (req_i) begin
            op_q <= req_op_i;
            if (req_op_i == OP_RD_BF) begin
              state_q <= StRdCyc;
              rs_q    <= 1'b0;
              rw_q    <= 1'b1;
              oe_q    <= 1'b0;
            end else begin
              state_q <= StSetAddr;
              rs_q    <= 1'b0;
              rw_q    <= 1'b0;
              oe_q    <= 1'b1;
              dout_q  <= CMD_SET_DDRAM | {1'b0, req_addr_i};
            end
          end
        end
        StSetAddr: begin
          if (bus_done) begin
            oe_q   <= 1'b0;
            dout_q <= '0;
`ifdef TEXTLCD_READER_BUSY_POLL_EN
            state_q    <= StPoll;
            rw_q       <= 1'b1;
            poll_cnt_q <= PollW'(1);
`else
            state_q    <= StExecWait;
            exec_cnt_q <= '0;
`endif
          end
        end
`ifdef TEXTLCD_READER_BUSY_POLL_EN
        StPoll: begin
          if (bus_done) begin
            if (!samp_q[7]) begin
              state_q <= StRdCyc;
              rs_q    <= (op_q == OP_RD_DATA);
            end else if (poll_give_up) begin
              state_q    <= StDone;
              rw_q       <= 1'b0;
              err_pend_q <= 1'b1;
            end else begin
              poll_cnt_q <= poll_cnt_q + 1'b1;
            end
          end
        end
`else
        StExecWait: begin
          if (exec_done) begin
            state_q <= StRdCyc;
            rs_q    <= (op_q == OP_RD_DATA);
            rw_q    <= 1'b1;
          end else begin
            exec_cnt_q <= exec_cnt_q + 1'b1;
          end
        end
`endif
        StRdCyc: begin
          if (bus_done) begin
            state_q <= StDone;
            rs_q    <= 1'b0;
            rw_q    <= 1'b0;
          end
        end
        StDone: begin
          rd_valid_q <= 1'b1;
          state_q    <= StIdle;
`ifdef TEXTLCD_READER_BUSY_POLL_EN
          rd_data_q  <= err_pend_q ? 8'hFF : samp_q;
          err_q      <= err_pend_q;
          err_pend_q <= 1'b0;
`else
          rd_data_q  <= samp_q;
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ready_o        = (state_q == StIdle);
  assign rd_valid_o     = rd_valid_q;
  assign rd_data_o      = rd_data_q;
  assign lcd_rs_o       = rs_q;
  assign lcd_rw_o       = rw_q;
  assign lcd_data_out_o = dout_q;
  assign lcd_data_oe_o  = oe_q;
`ifdef TEXTLCD_READER_BUSY_POLL_EN
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_textlcd_reader.sv
// Bench for textlcd_reader with short timing (SETUP=2, PULSE=4, HOLD=2,
// EXEC=10, POLL_MAX=3, so T=8). Table vectors, random ops against a
// transaction-level model, and hand sequences for reset, ignored requests
// and back-to-back acceptance.
module tb_textlcd_reader;

  localparam int SETUP = 2;
  localparam int PULSE = 4;
  localparam int HOLD  = 2;
  localparam int EXEC  = 10;
  localparam int PMAX  = 3;
  localparam int T     = SETUP + PULSE + HOLD;
  localparam int CYC_BUDGET = 200;

  logic       clk, rst_n;
  logic       req, req_op;
  logic [6:0] req_addr;
  logic       ready, rd_valid, err;
  logic [7:0] rd_data;
  logic       lcd_rs, lcd_rw, lcd_en, lcd_oe;
  logic [7:0] lcd_dout, lcd_din;

  textlcd_reader #(
    .SETUP_CYC (SETUP),
    .PULSE_CYC (PULSE),
    .HOLD_CYC  (HOLD),
    .EXEC_CYC  (EXEC),
    .POLL_MAX  (PMAX)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .req_i          (req),
    .req_op_i       (req_op),
    .req_addr_i     (req_addr),
    .ready_o        (ready),
    .rd_valid_o     (rd_valid),
    .rd_data_o      (rd_data),
    .err_o          (err),
    .lcd_rs_o       (lcd_rs),
    .lcd_rw_o       (lcd_rw),
    .lcd_en_o       (lcd_en),
    .lcd_data_out_o (lcd_dout),
    .lcd_data_oe_o  (lcd_oe),
    .lcd_data_in_i  (lcd_din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Pad data presented during each successive EN pulse of one operation.
  logic [7:0] seg_din [8];
  // Observed per-EN-pulse attributes.
  int         seg_en  [8];
  logic       seg_rs  [8];
  logic       seg_rw  [8];
  logic       seg_oe  [8];
  logic [7:0] seg_dout[8];
  int         res_nseg, res_lat, res_nvalid;
  logic [7:0] res_data;
  logic       res_err, res_ready_bad, res_unstable;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
    end
  endtask

  // Transaction-level model of one request, from the pad data per EN pulse.
  function automatic int first_clear_poll();
    for (int p = 1; p <= PMAX; p++) if (!seg_din[p][7]) return p;
    return 0;
  endfunction

  function automatic int model_lat(input logic op);
    if (!op) return T + 1;
`ifdef TEXTLCD_READER_BUSY_POLL_EN
    if (first_clear_poll() != 0) return T + first_clear_poll() * T + T + 1;
    return T + PMAX * T + 1;
`else
    return 2 * T + EXEC + 1;
`endif
  endfunction

  function automatic logic [7:0] model_data(input logic op);
    if (!op) return seg_din[0];
`ifdef TEXTLCD_READER_BUSY_POLL_EN
    if (first_clear_poll() != 0) return seg_din[first_clear_poll() + 1];
    return 8'hFF;
`else
    return seg_din[1];
`endif
  endfunction

  function automatic logic model_err(input logic op);
`ifdef TEXTLCD_READER_BUSY_POLL_EN
    return op && (first_clear_poll() == 0);
`else
    return 1'b0 & op;
`endif
  endfunction

  function automatic int model_nseg(input logic op);
    if (!op) return 1;
`ifdef TEXTLCD_READER_BUSY_POLL_EN
    if (first_clear_poll() != 0) return first_clear_poll() + 2;
    return PMAX + 1;
`else
    return 2;
`endif
  endfunction

  // Issue one request (called #1 after a rising edge with the DUT idle) and
  // watch until 20 clocks past the result. inj > 0 pulses a stray request.
  task automatic run_op(input logic op, input logic [6:0] addr, input int inj);
    logic prev_en;
    prev_en = 1'b0;
    res_nseg = 0; res_lat = -1; res_nvalid = 0;
    res_data = 8'hxx; res_err = 1'bx; res_ready_bad = 1'b0; res_unstable = 1'b0;
    for (int i = 0; i < 8; i++) seg_en[i] = 0;
    lcd_din = seg_din[0];
    req = 1'b1; req_op = op; req_addr = addr;
    @(posedge clk); #1;
    req = 1'b0;
    for (int k = 1; k <= CYC_BUDGET; k++) begin
      @(posedge clk); #1;
      if (lcd_en) begin
        if (res_nseg < 8) begin
          if (seg_en[res_nseg] == 0) begin
            seg_rs[res_nseg] = lcd_rs; seg_rw[res_nseg] = lcd_rw;
            seg_oe[res_nseg] = lcd_oe; seg_dout[res_nseg] = lcd_dout;
          end else if (lcd_rs !== seg_rs[res_nseg] || lcd_rw !== seg_rw[res_nseg] ||
                       lcd_oe !== seg_oe[res_nseg] || lcd_dout !== seg_dout[res_nseg]) begin
            res_unstable = 1'b1;
          end
          seg_en[res_nseg]++;
        end
      end else if (prev_en) begin
        res_nseg++;
        if (res_nseg < 8) lcd_din = seg_din[res_nseg];
      end
      prev_en = lcd_en;
      if (rd_valid) begin
        res_nvalid++;
        if (res_lat < 0) begin
          res_lat = k; res_data = rd_data; res_err = err;
          if (!ready) res_ready_bad = 1'b1;
        end
      end else if (ready && res_lat < 0) begin
        res_ready_bad = 1'b1;
      end
      req = 1'b0;
      if (k == inj) begin req = 1'b1; req_op = 1'b0; req_addr = 7'h11; end
      if (res_lat >= 0 && k >= res_lat + 20) break;
    end
    req = 1'b0;
  endtask

  task automatic check_op(input string tag, input logic op, input logic [6:0] addr);
    int n;
    n = model_nseg(op);
    check({tag, "_lat"}, res_lat, model_lat(op));
    check({tag, "_data"}, res_data, model_data(op));
    check({tag, "_err"}, res_err, model_err(op));
    check({tag, "_nvalid"}, res_nvalid, 1);
    check({tag, "_ready"}, res_ready_bad, 1'b0);
    check({tag, "_nseg"}, res_nseg, n);
    check({tag, "_stable"}, res_unstable, 1'b0);
    for (int i = 0; i < n && i < 8; i++) check({tag, "_enlen"}, seg_en[i], PULSE);
    if (op) begin
      check({tag, "_wr_attr"}, {seg_rs[0], seg_rw[0], seg_oe[0]}, 3'b001);
      check({tag, "_wr_dout"}, seg_dout[0], 8'h80 | {1'b0, addr});
      for (int i = 1; i < n - 1 && i < 8; i++)
        check({tag, "_poll_attr"}, {seg_rs[i], seg_rw[i], seg_oe[i]}, 3'b010);
      if (!model_err(op) && n <= 8)
        check({tag, "_rd_attr"}, {seg_rs[n-1], seg_rw[n-1], seg_oe[n-1]}, 3'b110);
    end else begin
      check({tag, "_rd_attr"}, {seg_rs[0], seg_rw[0], seg_oe[0]}, 3'b010);
    end
  endtask

  typedef struct {
    logic       op;
    logic [6:0] addr;
    logic [7:0] din;
    int         exp_lat;
    logic [7:0] exp_data;
  } vec_t;

  initial begin
    vec_t vecs[5];
    int   found, k1, k2;
    logic op;
    logic [6:0] addr;

    rst_n = 1'b0; req = 1'b0; req_op = 1'b0; req_addr = '0; lcd_din = '0;
    for (int i = 0; i < 8; i++) seg_din[i] = '0;
    #3;
    check("rst_en", lcd_en, 1'b0);
    check("rst_rs", lcd_rs, 1'b0);
    check("rst_rw", lcd_rw, 1'b0);
    check("rst_oe", lcd_oe, 1'b0);
    check("rst_dout", lcd_dout, 8'h00);
    check("rst_valid", rd_valid, 1'b0);
    check("rst_data", rd_data, 8'h00);
    check("rst_err", err, 1'b0);
    check("rst_ready", ready, 1'b1);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

`ifndef TEXTLCD_READER_BUSY_POLL_EN
    vecs[0] = '{1'b0, 7'h00, 8'h45, 9,  8'h45};
    vecs[1] = '{1'b1, 7'h41, 8'h41, 27, 8'h41};
    vecs[2] = '{1'b1, 7'h28, 8'hA5, 27, 8'hA5};
    vecs[3] = '{1'b1, 7'h7F, 8'h00, 27, 8'h00};
    vecs[4] = '{1'b0, 7'h33, 8'hFF, 9,  8'hFF};
    foreach (vecs[i]) begin
      for (int j = 0; j < 8; j++) seg_din[j] = vecs[i].din;
      if (vecs[i].op) seg_din[0] = ~vecs[i].din;
      run_op(vecs[i].op, vecs[i].addr, 0);
      check($sformatf("vec%0d_lat", i), res_lat, vecs[i].exp_lat);
      check($sformatf("vec%0d_data", i), res_data, vecs[i].exp_data);
      check_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].addr);
    end
`else
    // Busy for two polls, then clear: read proceeds.
    seg_din[0] = 8'h00; seg_din[1] = 8'h80; seg_din[2] = 8'hC5; seg_din[3] = 8'h12;
    seg_din[4] = 8'h41; seg_din[5] = 8'h00; seg_din[6] = 8'h00; seg_din[7] = 8'h00;
    run_op(1'b1, 7'h41, 0);
    check("poll_lat", res_lat, 5 * T + 1);
    check("poll_data", res_data, 8'h41);
    check_op("poll", 1'b1, 7'h41);
    // Busy flag stuck: timeout.
    for (int j = 0; j < 8; j++) seg_din[j] = 8'hFF;
    run_op(1'b1, 7'h05, 0);
    check("pto_data", res_data, 8'hFF);
    check("pto_err", res_err, 1'b1);
    check_op("pto", 1'b1, 7'h05);
    check("pto_err_cleared", err, 1'b0);
    seg_din[0] = 8'h45;
    run_op(1'b0, 7'h00, 0);
    check_op("op0", 1'b0, 7'h00);
`endif

    // Random requests against the model.
    for (int r = 0; r < 16; r++) begin
      op   = 1'($urandom_range(0, 1));
      addr = 7'($urandom);
      for (int j = 0; j < 8; j++) seg_din[j] = 8'($urandom);
      run_op(op, addr, 0);
      check_op($sformatf("rnd%0d", r), op, addr);
    end

    // Stray request during an op 1 is ignored.
    for (int j = 0; j < 8; j++) seg_din[j] = 8'h41;
    run_op(1'b1, 7'h41, 5);
    check_op("inject", 1'b1, 7'h41);

    // Reset at the first EN-high clock of a read cycle.
    seg_din[0] = 8'h45; lcd_din = 8'h45;
    req = 1'b1; req_op = 1'b0; req_addr = '0;
    @(posedge clk); #1;
    req = 1'b0;
    found = 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      if (lcd_en) begin found = 1; break; end
    end
    check("mrst_en_seen", found, 1);
    rst_n = 1'b0;
    #1;
    check("mrst_en", lcd_en, 1'b0);
    check("mrst_rw", lcd_rw, 1'b0);
    check("mrst_oe", lcd_oe, 1'b0);
    check("mrst_valid", rd_valid, 1'b0);
    check("mrst_ready", ready, 1'b1);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    seg_din[0] = 8'h3C;
    run_op(1'b0, 7'h00, 0);
    check_op("post_rst", 1'b0, 7'h00);

    // REQ held high across DONE is re-accepted in the first idle cycle.
    seg_din[0] = 8'h5A; lcd_din = 8'h5A;
    req = 1'b1; req_op = 1'b0; req_addr = '0;
    @(posedge clk); #1;
    k1 = -1; k2 = -1;
    for (int k = 1; k <= CYC_BUDGET; k++) begin
      @(posedge clk); #1;
      if (rd_valid) begin
        if (k1 < 0) k1 = k;
        else begin k2 = k; req = 1'b0; break; end
      end
    end
    req = 1'b0;
    check("hold_first", k1, T + 1);
    check("hold_gap", k2 - k1, T + 2);
    check("hold_data", rd_data, 8'h5A);
    repeat (T + 4) @(posedge clk);
    #1;
    check("hold_no_third", ready, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/textlcd_reader.md
Name: textlcd_reader

Overview:
- HD44780-style character-LCD read controller: the read-side counterpart to the team's text-LCD write sequencer.
- Accepts single-byte read requests from a host, drives the LCD bus with RW=1 read cycles, and returns either the busy-flag/address-counter byte or a DDRAM character.
- Sits between a diagnostic/readback host (e.g. display-content check, busy polling) and the shared LCD pins. It shares EN timing style with the writer: fixed setup, then a long EN-high pulse, then hold.

Parameters:
- SETUP_CYC, 200, clocks from bus-cycle start (RS/RW/DATA stable) to EN rise.
- PULSE_CYC, 1600, clocks EN is held high.
- HOLD_CYC, 100, clocks after EN fall before the bus cycle ends.
- EXEC_CYC, 2000, fixed wait after the set-DDRAM-address write (polling build: unused).
- POLL_MAX, 64, max busy-flag reads before timeout (polling build only).

Ports:
- CLK  in  1  system clock
- RESET_N  in  1  asynchronous active-low reset
- REQ  in  1  request strobe, sampled only when READY=1
- REQ_OP  in  1  0 = read BF/AC (RS=0), 1 = read DDRAM byte at REQ_ADDR
- REQ_ADDR  in  7  DDRAM address for op 1
- READY  out  1  high only in IDLE
- RD_VALID  out  1  one-cycle result pulse
- RD_DATA  out  8  result byte, held until next RD_VALID
- ERR  out  1  qualifies RD_VALID; timeout in polling build, constant 0 otherwise
- LCD_RS  out  1  register select
- LCD_RW  out  1  1 = read cycle
- LCD_EN  out  1  enable strobe
- LCD_DATA_OUT  out  8  write data for the address-set cycle
- LCD_DATA_OE  out  1  pad output enable; high only during write cycles
- LCD_DATA_IN  in  8  pad input

Behaviour:
- Reset (async, RESET_N=0) values:
  - LCD_EN=0, LCD_RS=0, LCD_RW=0, LCD_DATA_OE=0, LCD_DATA_OUT=0x00.
  - RD_VALID=0, RD_DATA=0x00, ERR=0.
  - State=IDLE, so READY=1.
  - Reset mid-operation aborts the transfer immediately and drops EN within the reset. No partial RD_VALID is produced.
- Bus cycle, T = SETUP_CYC+PULSE_CYC+HOLD_CYC clocks:
  - Phase counter runs 0..T-1. RS/RW/DATA_OUT/OE are registered at phase 0 and held stable for the whole cycle.
  - LCD_EN=1 for phases SETUP_CYC .. SETUP_CYC+PULSE_CYC-1.
  - LCD_DATA_IN is registered at phase SETUP_CYC+PULSE_CYC-1, the last EN-high clock.
- State machine (IDLE, SET_ADDR, EXEC_WAIT, RD_CYC, DONE):
  - IDLE: on REQ && READY, latch OP/ADDR. Go to RD_CYC if op 0, or SET_ADDR if op 1.
  - SET_ADDR: one write cycle with RS=0, RW=0, OE=1, DATA_OUT = 0x80 | {1'b0, ADDR}, then go to EXEC_WAIT.
  - EXEC_WAIT: count EXEC_CYC clocks, then go to RD_CYC.
  - RD_CYC: one read cycle with RW=1, OE=0, RS=OP, then go to DONE.
  - DONE: one clock with RD_VALID=1 and RD_DATA = the sampled byte, then return to IDLE.
- Latency from the accepting edge to RD_VALID:
  - op 0: T+1.
  - op 1: 2T+EXEC_CYC+1.
- Handshake edge cases:
  - REQ while not READY is ignored. There is no queueing.
  - REQ held high across DONE is accepted again in the first IDLE cycle.
- Address: no range check. Addresses 0x28–0x3F and 0x68–0x7F pass through unmodified.
- Op 0 result layout: RD_DATA[7] = BF, RD_DATA[6:0] = AC.

Optional Feature:
- Macro: TEXTLCD_READER_BUSY_POLL_EN.
- When defined, EXEC_WAIT is replaced by POLL:
  - Repeated read cycles with RS=0, RW=1.
  - Exit to RD_CYC on the first sample with DB7=0.
  - After POLL_MAX reads that all show BF=1, go to DONE with ERR=1 and RD_DATA=0xFF.
  - ERR is valid only with RD_VALID.
- When undefined: fixed EXEC_CYC wait, ERR tied 0, no poll counter synthesized.

Decomposition:
- Shared package textlcd_pkg holds:
  - CMD_SET_DDRAM = 8'h80.
  - Op encoding: OP_RD_BF = 0, OP_RD_DATA = 1.
  - State enum.
  - Default timing constants, shared with the writer.
- One sub-module, textlcd_bus_cycle:
  - Inputs: start.
  - Outputs: phase timer, LCD_EN, sample strobe, done strobe.
  - Parameterized by SETUP/PULSE/HOLD.
  - Reusable by the writer.

Test Plan (sim params SETUP=2, PULSE=4, HOLD=2, EXEC=10, POLL_MAX=3; T=8):
- Op 0 with LCD_DATA_IN=0x45 → EN high exactly 4 clocks with RS=0, RW=1, OE=0; RD_VALID 9 clocks after accept; RD_DATA=0x45.
- Op 1 with ADDR=0x41 and DATA_IN=0x41 during the read → write cycle with DATA_OUT=0xC1, OE=1, RS=0, RW=0; read cycle with RS=1, RW=1; RD_VALID 27 clocks after accept; RD_DATA=0x41.
- REQ pulsed during an active op 1 → ignored; READY=0 until DONE; exactly one RD_VALID.
- RESET_N low at the first EN-high clock of the read cycle → LCD_EN, RD_VALID, and OE drop immediately, READY=1; a post-reset op 0 completes normally.
- Polling build, DATA_IN[7]=1 for 2 polls then 0 → read proceeds, ERR=0. BF stuck at 1 → after 3 polls, RD_VALID with ERR=1 and RD_DATA=0xFF.
